// File: rtl/div_seq_if.sv
// Request/result bundle between a pipeline stage and the sequential divider.
// The pipeline drives the request side (master); the divider answers (slave).
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic               signed_i;
  logic               cancel_i;
  logic [WIDTH-1:0]   dividend_i;
  logic [WIDTH-1:0]   divider_i;
  logic [2*WIDTH-1:0] result_o;
  logic               success_o;
  logic               busy_o;
  logic               divZero_o;

  modport master (
    output start_i, signed_i, cancel_i, dividend_i, divider_i,
    input  result_o, success_o, busy_o, divZero_o
  );

  modport slave (
    input  start_i, signed_i, cancel_i, dividend_i, divider_i,
    output result_o, success_o, busy_o, divZero_o
  );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle restoring divider: WIDTH shift-subtract steps on magnitudes,
// followed by one step that applies the sign correction and publishes the result.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

  state_t             state_reg;
  logic [CW-1:0]      count_reg;
  logic [WIDTH-1:0]   rem_reg;
  logic [WIDTH-1:0]   quo_reg;
  logic [WIDTH-1:0]   div_reg;
  logic               signed_reg;
  logic               sign_a_reg;
  logic               sign_b_reg;
  logic [2*WIDTH-1:0] result_reg;
  logic               success_reg;
  logic               busy_reg;
  logic               divzero_reg;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     shifted;
  logic               fits;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    abs_a = bus.dividend_i;
    abs_b = bus.divider_i;
    if (bus.signed_i && bus.dividend_i[WIDTH-1]) abs_a = -bus.dividend_i;
    if (bus.signed_i && bus.divider_i[WIDTH-1])  abs_b = -bus.divider_i;
    shifted = {rem_reg, quo_reg[WIDTH-1]};
    fits    = shifted >= {1'b0, div_reg};
    // The partial remainder after a successful subtract is below the divisor,
    // so the low WIDTH bits of the difference are exact.
    diff    = shifted[WIDTH-1:0] - div_reg;
    quo_fix = (signed_reg && (sign_a_reg ^ sign_b_reg)) ? -quo_reg : quo_reg;
    rem_fix = (signed_reg && sign_a_reg) ? -rem_reg : rem_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      div_reg     <= '0;
      signed_reg  <= 1'b0;
      sign_a_reg  <= 1'b0;
      sign_b_reg  <= 1'b0;
      result_reg  <= '0;
      success_reg <= 1'b0;
      busy_reg    <= 1'b0;
      divzero_reg <= 1'b0;
    end else if (state_reg != IDLE && bus.cancel_i) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      result_reg  <= '0;
      success_reg <= 1'b0;
      busy_reg    <= 1'b0;
      divzero_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start_i && !bus.cancel_i) begin
            busy_reg <= 1'b1;
            if (bus.divider_i == '0) begin
              state_reg <= DIVZERO;
            end else begin
              state_reg  <= ON;
              count_reg  <= '0;
              rem_reg    <= '0;
              quo_reg    <= abs_a;
              div_reg    <= abs_b;
              signed_reg <= bus.signed_i;
              sign_a_reg <= bus.signed_i & bus.dividend_i[WIDTH-1];
              sign_b_reg <= bus.signed_i & bus.divider_i[WIDTH-1];
            end
          end
        end
        DIVZERO: begin
          state_reg   <= END;
          result_reg  <= '0;
          success_reg <= 1'b1;
          divzero_reg <= 1'b1;
        end
        ON: begin
          if (count_reg == CW'(WIDTH)) begin
            state_reg   <= END;
            result_reg  <= {rem_fix, quo_fix};
            success_reg <= 1'b1;
          end else begin
            rem_reg   <= fits ? diff : shifted[WIDTH-1:0];
            quo_reg   <= {quo_reg[WIDTH-2:0], fits};
            count_reg <= count_reg + CW'(1);
          end
        end
        END: begin
          if (!bus.start_i) begin
            state_reg   <= IDLE;
            result_reg  <= '0;
            success_reg <= 1'b0;
            busy_reg    <= 1'b0;
            divzero_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.result_o  = result_reg;
  assign bus.success_o = success_reg;
  assign bus.busy_o    = busy_reg;
  assign bus.divZero_o = divzero_reg;
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq at WIDTH=32: latency, signed/unsigned results,
// divide-by-zero, cancel, reset mid-operation and the END handshake.
module tb_div_seq;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  div_seq_if #(.WIDTH(WIDTH)) bus ();
  div_seq #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic sg, input logic cn,
                       input logic [31:0] a, input logic [31:0] b);
    bus.start_i    = st;
    bus.signed_i   = sg;
    bus.cancel_i   = cn;
    bus.dividend_i = a;
    bus.divider_i  = b;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 32'd0, 32'd0);
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus.result_o !== 64'd0) begin n_bad++; $display("FAIL reset_result got %h want 0", bus.result_o); end
    n_cmp++; if (bus.success_o !== 1'b0) begin n_bad++; $display("FAIL reset_success got %b want 0", bus.success_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.divZero_o !== 1'b0) begin n_bad++; $display("FAIL reset_divzero got %b want 0", bus.divZero_o); end
    rst = 1'b0;
    tick();
    $display("reset: result=%h busy=%b", bus.result_o, bus.busy_o);
  endtask

  task automatic test_unsigned();
    int edges;
    drive(1, 0, 0, 32'd100, 32'd7);
    tick();
    n_cmp++; if (bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL u_busy got %b want 1", bus.busy_o); end
    // operands must be ignored once the operation is running
    drive(1, 1, 0, 32'd999, 32'd1);
    edges = 0;
    while (bus.success_o !== 1'b1 && edges < 40) begin tick(); edges++; end
    n_cmp++; if (edges !== 33) begin n_bad++; $display("FAIL u_latency got %0d want 33", edges); end
    n_cmp++; if (bus.result_o !== {32'h2, 32'hE}) begin n_bad++; $display("FAIL u_result got %h want %h", bus.result_o, {32'h2, 32'hE}); end
    n_cmp++; if (bus.divZero_o !== 1'b0) begin n_bad++; $display("FAIL u_divzero got %b want 0", bus.divZero_o); end
    tick();
    n_cmp++; if (bus.result_o !== {32'h2, 32'hE} || bus.success_o !== 1'b1) begin n_bad++; $display("FAIL u_hold got %h/%b want %h/1", bus.result_o, bus.success_o, {32'h2, 32'hE}); end
    $display("unsigned 100/7: result=%h edges=%0d", bus.result_o, edges);
    drive(0, 0, 0, 32'd0, 32'd0);
    tick();
    n_cmp++; if (bus.success_o !== 1'b0 || bus.result_o !== 64'd0 || bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL u_release got s=%b r=%h b=%b want 0/0/0", bus.success_o, bus.result_o, bus.busy_o); end
  endtask

  task automatic test_signed();
    logic        sg [6];
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [63:0] ve [6];
    int edges;
    sg[0] = 1; va[0] = 32'hFFFFFF9C; vb[0] = 32'h00000007; ve[0] = {32'hFFFFFFFE, 32'hFFFFFFF2};
    sg[1] = 1; va[1] = 32'h00000064; vb[1] = 32'hFFFFFFF9; ve[1] = {32'h00000002, 32'hFFFFFFF2};
    sg[2] = 1; va[2] = 32'h80000000; vb[2] = 32'hFFFFFFFF; ve[2] = {32'h00000000, 32'h80000000};
    sg[3] = 0; va[3] = 32'hFFFFFFFF; vb[3] = 32'h00000003; ve[3] = {32'h00000000, 32'h55555555};
    sg[4] = 0; va[4] = 32'h80000000; vb[4] = 32'hFFFFFFFF; ve[4] = {32'h80000000, 32'h00000000};
    sg[5] = 1; va[5] = 32'hFFFFFFF9; vb[5] = 32'hFFFFFFFE; ve[5] = {32'hFFFFFFFF, 32'h00000003};
    for (int i = 0; i < 6; i++) begin
      drive(1, sg[i], 0, va[i], vb[i]);
      tick();
      edges = 0;
      while (bus.success_o !== 1'b1 && edges < 40) begin tick(); edges++; end
      n_cmp++; if (edges !== 33) begin n_bad++; $display("FAIL vec%0d_latency got %0d want 33", i, edges); end
      n_cmp++; if (bus.result_o !== ve[i]) begin n_bad++; $display("FAIL vec%0d_result got %h want %h", i, bus.result_o, ve[i]); end
      n_cmp++; if (bus.divZero_o !== 1'b0) begin n_bad++; $display("FAIL vec%0d_divzero got %b want 0", i, bus.divZero_o); end
      $display("div s=%b %h/%h: result=%h", sg[i], va[i], vb[i], bus.result_o);
      drive(0, 0, 0, 32'd0, 32'd0);
      tick();
    end
  endtask

  task automatic test_divzero();
    drive(1, 0, 0, 32'h12345678, 32'd0);
    tick();
    n_cmp++; if (bus.success_o !== 1'b0 || bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL dz_first got s=%b b=%b want 0/1", bus.success_o, bus.busy_o); end
    tick();
    n_cmp++; if (bus.success_o !== 1'b1) begin n_bad++; $display("FAIL dz_success got %b want 1", bus.success_o); end
    n_cmp++; if (bus.divZero_o !== 1'b1) begin n_bad++; $display("FAIL dz_flag got %b want 1", bus.divZero_o); end
    n_cmp++; if (bus.result_o !== 64'd0) begin n_bad++; $display("FAIL dz_result got %h want 0", bus.result_o); end
    $display("divzero 12345678/0: result=%h divZero=%b", bus.result_o, bus.divZero_o);
    drive(0, 0, 0, 32'd0, 32'd0);
    tick();
    n_cmp++; if (bus.divZero_o !== 1'b0 || bus.success_o !== 1'b0) begin n_bad++; $display("FAIL dz_release got dz=%b s=%b want 0/0", bus.divZero_o, bus.success_o); end
  endtask

  task automatic test_cancel();
    logic seen;
    int   edges;
    drive(1, 0, 0, 32'hFFFFFFFF, 32'd3);
    tick();
    seen = 1'b0;
    repeat (10) begin tick(); if (bus.success_o === 1'b1) seen = 1'b1; end
    drive(0, 0, 1, 32'd0, 32'd0);
    tick();
    if (bus.success_o === 1'b1) seen = 1'b1;
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL cancel_busy got %b want 0", bus.busy_o); end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL cancel_success got %b want 0", seen); end
    n_cmp++; if (bus.result_o !== 64'd0) begin n_bad++; $display("FAIL cancel_result got %h want 0", bus.result_o); end
    drive(1, 0, 0, 32'd9, 32'd3);
    tick();
    edges = 0;
    while (bus.success_o !== 1'b1 && edges < 40) begin tick(); edges++; end
    n_cmp++; if (edges !== 33) begin n_bad++; $display("FAIL restart_latency got %0d want 33", edges); end
    n_cmp++; if (bus.result_o !== {32'd0, 32'd3}) begin n_bad++; $display("FAIL restart_result got %h want %h", bus.result_o, {32'd0, 32'd3}); end
    $display("cancel then 9/3: result=%h", bus.result_o);
    // cancel while parked in END with start still held
    drive(1, 0, 1, 32'd9, 32'd3);
    tick();
    n_cmp++; if (bus.success_o !== 1'b0 || bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL end_cancel got s=%b b=%b want 0/0", bus.success_o, bus.busy_o); end
    // start together with cancel in IDLE is ignored
    tick();
    tick();
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL idle_cancel got busy=%b want 0", bus.busy_o); end
    drive(0, 0, 0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 32'hFFFFFFFF, 32'd3);
    tick();
    repeat (20) tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (bus.busy_o !== 1'b0 || bus.success_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_flags got b=%b s=%b want 0/0", bus.busy_o, bus.success_o); end
    n_cmp++; if (bus.result_o !== 64'd0 || bus.divZero_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_result got %h dz=%b want 0/0", bus.result_o, bus.divZero_o); end
    tick();
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL rst_priority got busy=%b want 0", bus.busy_o); end
    $display("reset mid-iteration: busy=%b result=%h", bus.busy_o, bus.result_o);
    rst = 1'b0;
    drive(0, 0, 0, 32'd0, 32'd0);
    tick();
  endtask

  initial begin
    drive(0, 0, 0, 32'd0, 32'd0);
    test_reset();
    test_unsigned();
    test_signed();
    test_divzero();
    test_cancel();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits (legal range 4..64).
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset; synchronous and active-high.
REQ-004 Port start_i  input  1  request a division; sampled only in IDLE.
REQ-005 Port signed_i  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start_i.
REQ-006 Port cancel_i  input  1  abort any operation in progress.
REQ-007 Port dividend_i  input  WIDTH  dividend; sampled with start_i.
REQ-008 Port divider_i  input  WIDTH  divisor; sampled with start_i.
REQ-009 Port result_o  output  2*WIDTH  {remainder, quotient}, remainder in the upper half.
REQ-010 Port success_o  output  1  result_o is valid.
REQ-011 Port busy_o  output  1  high in every state except IDLE; the pipeline stalls on this.
REQ-012 Port divZero_o  output  1  current result came from a zero divisor.

Function
REQ-013 States SHALL be IDLE, DIVZERO, ON and END, held in a registered state machine.
REQ-014 IDLE + start_i=1 + cancel_i=0 + divider_i!=0 SHALL go to ON, latching |dividend|, |divider|, signed_i and both operand signs.
REQ-015 IDLE + start_i=1 + cancel_i=0 + divider_i=0 SHALL go to DIVZERO.
REQ-016 IDLE + start_i=1 + cancel_i=1 SHALL stay in IDLE and accept nothing.
REQ-017 ON SHALL perform exactly WIDTH restoring shift-subtract iterations, one per clock, using a ceil(log2(WIDTH+1))-bit counter.
REQ-018 After the final iteration, ON SHALL go to END.
REQ-019 success_o SHALL first be high WIDTH+1 rising edges after the edge that sampled start_i.
REQ-020 DIVZERO SHALL last one cycle, then go to END with result_o=0 and divZero_o=1.
  - success_o therefore rises 2 edges after start_i is sampled.
REQ-021 In END, success_o=1 and result_o SHALL hold stable.
REQ-022 END SHALL stay in END while start_i=1 and go to IDLE on the first edge with start_i=0.
REQ-023 On the END->IDLE edge, success_o, divZero_o and result_o SHALL clear to 0.
REQ-024 cancel_i=1 in ON, DIVZERO or END SHALL force IDLE on the next edge.
  - Outputs clear to 0; success_o is never asserted for a cancelled operation.
REQ-025 cancel_i SHALL take priority over iteration completion when both occur on the same cycle.
REQ-026 Sign correction for signed_i=1:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Result satisfies q*d + r = dividend, modulo 2^WIDTH.
REQ-027 Signed most-negative value divided by -1 SHALL return quotient = most-negative value (wrap) and remainder 0, with no flag.
REQ-028 For signed_i=0, operands SHALL be treated as unsigned; no negation is applied.
REQ-029 Input changes while not in IDLE SHALL have no effect, except cancel_i and start_i in END.
REQ-030 A new start_i SHALL be accepted no sooner than one cycle in IDLE after END.

Reset
REQ-031 On rst=1 at a clock edge:
  - State goes to IDLE from any state, including mid-iteration.
  - result_o=0, success_o=0, busy_o=0, divZero_o=0.
  - Counter and internal registers cleared.
REQ-032 rst SHALL take priority over start_i and cancel_i.

Verification (WIDTH=32)
REQ-033 Unsigned 100/7, start held high:
  - success_o rises 33 edges after sampling.
  - result_o = {0x00000002, 0x0000000E}.
  - Drop start_i -> IDLE next edge, outputs 0.
REQ-034 Signed -100/7 (0xFFFFFF9C / 0x00000007) -> result_o = {0xFFFFFFFE, 0xFFFFFFF2}.
REQ-035 Signed 100/-7 -> result_o = {0x00000002, 0xFFFFFFF2}.
REQ-036 Divisor 0, dividend 0x12345678 -> success_o high 2 edges later, divZero_o=1, result_o=0.
REQ-037 Start 0xFFFFFFFF/3, then cancel_i=1 at iteration 10:
  - IDLE next edge, success_o never high.
  - Immediate restart 9/3 -> {0, 3}.
REQ-038 Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
REQ-039 Assert rst at iteration 20 -> all outputs 0 next edge; busy_o=0.
